alarm_controller: RTL and testbench
===================================

// Module: alarm_controller
// PURPOSE
//   Consumes the BCD time digits produced by the system time counter and decides
//   when the alarm rings. Holds the user-set alarm time, detects the HH:MM match,
//   and drives the buzzer. Supports stop, snooze and auto-timeout via a 4-state FSM.
//   Sits between the system counter and the buzzer/LED outputs.
// PARAMETERS
//   SNOOZE_MIN        5   snooze length in minutes; legal range 1..59
//   RING_TIMEOUT_SEC  60  ringing auto-stops after this many sec_tick pulses; >=2
// PORTS
//   clk            in   1  system clock
//   reset          in   1  asynchronous, active-high; clears all state
//   sec_tick       in   1  one-clk-wide pulse once per second (from clock divider)
//   min_units      in   4  current minutes units, BCD 0..9
//   min_tens       in   3  current minutes tens, 0..5
//   hour_units     in   4  current hours units, BCD 0..9
//   hour_tens      in   3  current hours tens, 0..2
//   alarm_load     in   1  one-clk pulse: capture alarm_minutes/alarm_hours
//   alarm_minutes  in   6  alarm minutes, binary 0..59
//   alarm_hours    in   5  alarm hours, binary 0..23
//   alarm_enable   in   1  level: alarm armed when 1
//   stop_btn       in   1  one-clk pulse (debounced upstream)
//   snooze_btn     in   1  one-clk pulse (debounced upstream)
//   buzzer         out  1  beep output, registered
//   alarm_active   out  1  1 when state != IDLE, registered
//   state          out  2  IDLE=0 ARMED=1 RINGING=2 SNOOZE=3
// BEHAVIOUR
//   Reset: state=IDLE, stored alarm 00:00, buzzer=0, alarm_active=0, counters=0,
//     match_d=1.
//   Alarm store: on alarm_load, store hours/10, hours%10, min/10, min%10 as BCD.
//     Out-of-range load (min>59 or hr>23): ignored, nothing changes.
//     A valid load also sets match_d=1 and, if state is RINGING/SNOOZE, goes to ARMED.
//   match = all four current digits equal stored digits (combinational);
//     match_d <= match every clk in every state; match_rise = match & ~match_d.
//     Loading or enabling while time already equals alarm does not ring.
//   FSM (registered, one clk per transition). alarm_enable=0 forces IDLE from any
//     state next clk; counters cleared; buzzer=0. This has the highest priority.
//   IDLE:    alarm_enable=1 -> ARMED.
//   ARMED:   match_rise -> RINGING; ring_cnt=0; buzzer=1.
//   RINGING: priority stop_btn > snooze_btn > sec_tick.
//     stop_btn -> ARMED, buzzer=0.
//     snooze_btn -> SNOOZE, snooze_cnt=SNOOZE_MIN*60, buzzer=0.
//     sec_tick: buzzer toggles (1 s on / 1 s off). ring_cnt++.
//       If ring_cnt==RING_TIMEOUT_SEC-1 at the tick -> ARMED, buzzer=0.
//   SNOOZE:  stop_btn -> ARMED.
//     sec_tick: snooze_cnt--. If snooze_cnt==1 at the tick -> RINGING,
//       ring_cnt=0, buzzer=1.
//   match_rise in RINGING/SNOOZE is ignored. snooze_btn outside RINGING is ignored.
//     stop_btn in IDLE/ARMED is ignored.
//   Widths: ring_cnt = $clog2(RING_TIMEOUT_SEC); snooze_cnt = $clog2(SNOOZE_MIN*60+1).
//     Neither counter wraps.
//   A later counter-driven 23:59->00:00 rollover needs no special case:
//     match is evaluated on digits only.
// TESTING
//   1 Load 07:30, enable, drive digits 07:29 then 07:30
//     -> state=2, buzzer=1 the clk after the change; alarm_active=1.
//   2 Ringing, issue 3 sec_ticks -> buzzer 0,1,0; stop_btn -> state=1, buzzer=0;
//     digits held at 07:30 -> no re-ring.
//   3 Ringing, snooze_btn -> state=3; after 299 ticks state=3; at 300th tick
//     -> state=2, buzzer=1 (SNOOZE_MIN=5).
//   4 Ringing untouched for 60 ticks -> state=1, buzzer=0 on the 60th tick.
//   5 Digits = 12:00, load alarm 12:00 -> no ring; load min=60 -> stored alarm
//     unchanged; stop_btn+snooze_btn same clk while ringing -> ARMED.
//   6 Assert reset mid-RINGING and in SNOOZE -> all outputs 0 immediately
//     (asynchronous); drop alarm_enable while RINGING -> IDLE, buzzer=0 next clk.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm controller: stores a BCD alarm time, rings on the rising edge of an HH:MM
// match and handles stop, snooze and ring timeout with a four-state FSM.
module alarm_controller #(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [3:0] min_units,
  input  logic [2:0] min_tens,
  input  logic [3:0] hour_units,
  input  logic [2:0] hour_tens,
  input  logic       alarm_load,
  input  logic [5:0] alarm_minutes,
  input  logic [4:0] alarm_hours,
  input  logic       alarm_enable,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic       alarm_active,
  output logic [1:0] state
);

  localparam int RW = $clog2(RING_TIMEOUT_SEC);
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_TIMEOUT_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MIN * 60);
  localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [RW-1:0]   r_ring_cnt;
  logic [RW-1:0]   w_ring_cnt_nx;
  logic [SW-1:0]   r_snooze_cnt;
  logic [SW-1:0]   w_snooze_cnt_nx;
  logic            r_buzzer;
  logic            w_buzzer_nx;
  logic            r_active;
  logic            r_match_d;
  logic [2:0]      r_al_ht;
  logic [3:0]      r_al_hu;
  logic [2:0]      r_al_mt;
  logic [3:0]      r_al_mu;

  logic            w_load_ok;
  logic            w_match;
  logic            w_match_rise;
  logic [2:0]      w_ld_ht;
  logic [3:0]      w_ld_hu;
  logic [2:0]      w_ld_mt;
  logic [3:0]      w_ld_mu;

  assign w_load_ok = alarm_load && (alarm_minutes <= 6'd59) && (alarm_hours <= 5'd23);
  assign w_ld_ht   = 3'(alarm_hours / 5'd10);
  assign w_ld_hu   = 4'(alarm_hours % 5'd10);
  assign w_ld_mt   = 3'(alarm_minutes / 6'd10);
  assign w_ld_mu   = 4'(alarm_minutes % 6'd10);

  assign w_match = (hour_tens == r_al_ht) && (hour_units == r_al_hu) &&
                   (min_tens == r_al_mt) && (min_units == r_al_mu);
  // A load in the same clk re-baselines the edge detector, so it must not ring.
  assign w_match_rise = w_match && !r_match_d && !w_load_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_al_ht   <= '0;
      r_al_hu   <= '0;
      r_al_mt   <= '0;
      r_al_mu   <= '0;
      r_match_d <= 1'b1;
    end else begin
      r_match_d <= w_load_ok ? 1'b1 : w_match;
      if (w_load_ok) begin
        r_al_ht <= w_ld_ht;
        r_al_hu <= w_ld_hu;
        r_al_mt <= w_ld_mt;
        r_al_mu <= w_ld_mu;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (!alarm_enable) begin
      w_state_nx = IDLE;
    end else if (w_load_ok && (r_state == RINGING || r_state == SNOOZE)) begin
      w_state_nx = ARMED;
    end else begin
      case (r_state)
        IDLE:    w_state_nx = ARMED;
        ARMED:   if (w_match_rise) w_state_nx = RINGING;
        RINGING: begin
          if (stop_btn)                                  w_state_nx = ARMED;
          else if (snooze_btn)                           w_state_nx = SNOOZE;
          else if (sec_tick && r_ring_cnt == RING_LAST)  w_state_nx = ARMED;
        end
        SNOOZE: begin
          if (stop_btn)                                     w_state_nx = ARMED;
          else if (sec_tick && r_snooze_cnt == SNOOZE_ONE)  w_state_nx = RINGING;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Counters and buzzer: entry actions on a state change, else per-tick updates.
  always_comb begin
    w_ring_cnt_nx   = r_ring_cnt;
    w_snooze_cnt_nx = r_snooze_cnt;
    w_buzzer_nx     = r_buzzer;
    if (w_state_nx == IDLE) begin
      w_ring_cnt_nx   = '0;
      w_snooze_cnt_nx = '0;
      w_buzzer_nx     = 1'b0;
    end else if (w_state_nx != r_state) begin
      case (w_state_nx)
        RINGING: begin
          w_ring_cnt_nx = '0;
          w_buzzer_nx   = 1'b1;
        end
        SNOOZE: begin
          w_snooze_cnt_nx = SNOOZE_LOAD;
          w_buzzer_nx     = 1'b0;
        end
        default: w_buzzer_nx = 1'b0;
      endcase
    end else if (r_state == RINGING && sec_tick) begin
      w_ring_cnt_nx = r_ring_cnt + 1'b1;
      w_buzzer_nx   = ~r_buzzer;
    end else if (r_state == SNOOZE && sec_tick) begin
      w_snooze_cnt_nx = r_snooze_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_buzzer     <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_ring_cnt   <= w_ring_cnt_nx;
      r_snooze_cnt <= w_snooze_cnt_nx;
      r_buzzer     <= w_buzzer_nx;
      r_active     <= (w_state_nx != IDLE);
    end
  end

  assign buzzer       = r_buzzer;
  assign alarm_active = r_active;
  assign state        = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random traffic, all checked
// against a minute-of-day / seconds-remaining model of the alarm.
module tb_alarm_controller;
  localparam int SNOOZE_MIN       = 5;
  localparam int RING_TIMEOUT_SEC = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick, alarm_load, alarm_enable, stop_btn, snooze_btn;
  logic [3:0] min_units, hour_units;
  logic [2:0] min_tens, hour_tens;
  logic [5:0] alarm_minutes;
  logic [4:0] alarm_hours;
  logic       buzzer, alarm_active;
  logic [1:0] state;

  alarm_controller #(.SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .min_units(min_units), .min_tens(min_tens),
    .hour_units(hour_units), .hour_tens(hour_tens),
    .alarm_load(alarm_load), .alarm_minutes(alarm_minutes), .alarm_hours(alarm_hours),
    .alarm_enable(alarm_enable), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .buzzer(buzzer), .alarm_active(alarm_active), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: mode 0..3, alarm as minute of day, seconds rung, seconds of snooze left.
  int m_mode, m_alarm, m_match_d, m_ring_secs, m_snooze_left, m_buz;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_alarm = 0; m_match_d = 1; m_ring_secs = 0; m_snooze_left = 0; m_buz = 0;
  endtask

  task automatic model_step();
    int now_min;
    bit match, rise, load_ok;
    now_min = (hour_tens * 10 + hour_units) * 60 + min_tens * 10 + min_units;
    match   = (now_min == m_alarm);
    load_ok = alarm_load && alarm_minutes <= 59 && alarm_hours <= 23;
    rise    = match && !m_match_d && !load_ok;
    if (!alarm_enable) begin
      m_mode = 0; m_buz = 0; m_ring_secs = 0; m_snooze_left = 0;
    end else if (load_ok && m_mode >= 2) begin
      m_mode = 1; m_buz = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (rise) begin m_mode = 2; m_ring_secs = 0; m_buz = 1; end
        2: begin
          if (stop_btn) begin m_mode = 1; m_buz = 0; end
          else if (snooze_btn) begin m_mode = 3; m_snooze_left = SNOOZE_MIN * 60; m_buz = 0; end
          else if (sec_tick) begin
            m_ring_secs++;
            if (m_ring_secs == RING_TIMEOUT_SEC) begin m_mode = 1; m_buz = 0; end
            else m_buz = (m_ring_secs % 2 == 0) ? 1 : 0;
          end
        end
        default: begin
          if (stop_btn) m_mode = 1;
          else if (sec_tick) begin
            m_snooze_left--;
            if (m_snooze_left == 0) begin m_mode = 2; m_ring_secs = 0; m_buz = 1; end
          end
        end
      endcase
    end
    m_match_d = load_ok ? 1 : int'(match);
    if (load_ok) m_alarm = alarm_hours * 60 + alarm_minutes;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_state"}, state, m_mode);
    check({tag, "_buzzer"}, buzzer, m_buz);
    check({tag, "_active"}, alarm_active, (m_mode != 0) ? 1 : 0);
    sec_tick = 0; alarm_load = 0; stop_btn = 0; snooze_btn = 0;
  endtask

  task automatic set_time(input int h, input int m);
    hour_tens = 3'(h / 10); hour_units = 4'(h % 10);
    min_tens  = 3'(m / 10); min_units  = 4'(m % 10);
  endtask

  task automatic load_alarm(input int h, input int m);
    alarm_hours = 5'(h); alarm_minutes = 6'(m); alarm_load = 1;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1;
      step(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    reset = 1;
    #1;
    check({tag, "_state"}, state, 0);
    check({tag, "_buzzer"}, buzzer, 0);
    check({tag, "_active"}, alarm_active, 0);
    #2;
    reset = 0;
    model_reset();
  endtask

  initial begin
    reset = 1; sec_tick = 0; alarm_load = 0; alarm_enable = 0; stop_btn = 0; snooze_btn = 0;
    alarm_minutes = 0; alarm_hours = 0;
    set_time(7, 29);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_active", alarm_active, 0);
    reset = 0;

    // 1: ring on 07:29 -> 07:30
    load_alarm(7, 30); alarm_enable = 1;
    step("t1_load");
    step("t1_arm");
    set_time(7, 30);
    step("t1_ring");
    check("t1_ring_state", state, 2);
    check("t1_ring_buz", buzzer, 1);

    // 2: buzzer toggles, stop, no re-ring while held
    sec_tick = 1; step("t2_tick1"); check("t2_b1", buzzer, 0);
    sec_tick = 1; step("t2_tick2"); check("t2_b2", buzzer, 1);
    sec_tick = 1; step("t2_tick3"); check("t2_b3", buzzer, 0);
    stop_btn = 1; step("t2_stop"); check("t2_stop_state", state, 1);
    repeat (5) step("t2_hold");
    check("t2_no_rering", state, 1);

    // 3: snooze for SNOOZE_MIN*60 ticks
    set_time(7, 31); step("t3_away");
    set_time(7, 30); step("t3_ring");
    snooze_btn = 1; step("t3_snooze"); check("t3_snz_state", state, 3);
    ticks(SNOOZE_MIN * 60 - 1, "t3_wait");
    check("t3_before", state, 3);
    ticks(1, "t3_last");
    check("t3_rering_state", state, 2);
    check("t3_rering_buz", buzzer, 1);

    // 4: timeout
    ticks(RING_TIMEOUT_SEC - 1, "t4_ring");
    check("t4_before", state, 2);
    ticks(1, "t4_last");
    check("t4_timeout_state", state, 1);
    check("t4_timeout_buz", buzzer, 0);

    // 5: load while matching, invalid load, stop+snooze together
    set_time(12, 0); step("t5_set");
    load_alarm(12, 0); step("t5_load");
    repeat (3) step("t5_hold");
    check("t5_no_ring", state, 1);
    load_alarm(12, 60); step("t5_bad");
    load_alarm(24, 0); step("t5_bad_hr");
    set_time(11, 59); step("t5_away");
    set_time(12, 0); step("t5_back");
    check("t5_kept_alarm", state, 2);
    stop_btn = 1; snooze_btn = 1; step("t5_both");
    check("t5_both_state", state, 1);

    // 6: async reset in RINGING and SNOOZE, enable drop
    set_time(11, 59); step("t6_away");
    set_time(12, 0); step("t6_ring");
    async_reset("t6_rst_ring");
    step("t6_idle");
    step("t6_arm");
    check("t6_alarm_cleared", state, 1);
    load_alarm(12, 0); step("t6_reload");
    set_time(11, 59); step("t6_away2");
    set_time(12, 0); step("t6_ring2");
    snooze_btn = 1; step("t6_snz");
    ticks(4, "t6_snz_t");
    async_reset("t6_rst_snz");
    step("t6_idle2");
    load_alarm(12, 0); step("t6_reload2");
    set_time(11, 59); step("t6_away3");
    set_time(12, 0); step("t6_ring3");
    alarm_enable = 0; step("t6_disable");
    check("t6_dis_state", state, 0);
    check("t6_dis_buz", buzzer, 0);
    alarm_enable = 1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) set_time(m_alarm / 60, m_alarm % 60);
      else if (r < 22) set_time($urandom_range(0, 23), $urandom_range(0, 59));
      sec_tick   = ($urandom_range(0, 99) < 50);
      stop_btn   = ($urandom_range(0, 99) < 2);
      snooze_btn = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 2) load_alarm($urandom_range(0, 31), $urandom_range(0, 63));
      if ($urandom_range(0, 999) < 5) alarm_enable = ~alarm_enable;
      else if (!alarm_enable && $urandom_range(0, 99) < 20) alarm_enable = 1;
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
